vchip8_keypad_scanner: RTL and testbench

//  Scans the 4x4 CHIP-8 hex keypad matrix and debounces every key.

---
 rtl/vchip8_keypad_pkg.sv | 29 ++
 rtl/vchip8_key_debounce.sv | 50 +++++
 rtl/vchip8_keypad_scanner.sv | 145 ++++++++++++++
 tb/tb_vchip8_keypad_scanner.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vchip8_keypad_pkg.sv
// Shared types and constants for the CHIP-8 keypad scanner.
package vchip8_keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned KEYS = ROWS * COLS;
  localparam int unsigned RowW = $clog2(ROWS);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StUpdate
  } scan_state_e;

  // Physical (row, col) position to CHIP-8 key index.
  localparam logic [3:0] KEY_MAP [ROWS][COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hC},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hA, 4'h0, 4'hB, 4'hF}
  };

  // Active-low one-hot drive pattern for a row.
  function automatic logic [ROWS-1:0] row_drive(input logic [RowW-1:0] row);
    return ~(ROWS'(1) << row);
  endfunction

endpackage

// File: rtl/vchip8_key_debounce.sv
// Per-key debouncer: flips the held state after DEBOUNCE_SCANS consecutive
// disagreeing frames, evaluated only when update is high.
module vchip8_key_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic update,
  input  logic raw,
  output logic state,
  output logic changed
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            state_q, state_d;

  // Disagreement counter and state flip on the final disagreeing frame.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    changed = 1'b0;
    if (update) begin
      if (raw == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(DEBOUNCE_SCANS - 1)) begin
        state_d = raw;
        cnt_d   = '0;
        changed = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Counter and state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/vchip8_keypad_scanner.sv
// 4x4 CHIP-8 hex keypad scanner with per-key debounce; key_state feeds the
// keypad PIO in_port directly.
module vchip8_keypad_scanner
  import vchip8_keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 500,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            scan_enable,
  input  logic [COLS-1:0] col_n,
  output logic [ROWS-1:0] row_n,
  output logic [KEYS-1:0] key_state,
  output logic            key_event
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES - 1);

  logic [COLS-1:0]    col_meta_q, col_s_q;
  scan_state_e        state_q, state_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic [ROWS-1:0]    row_n_q, row_n_d;
  logic [KEYS-1:0]    raw_q, raw_d;
  logic [KEYS-1:0]    changed;
  logic               update;
  logic               key_event_q;

  // Two-flop synchronizer; idle level of the pulled-up columns is all ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_meta_q <= '1;
      col_s_q    <= '1;
    end else begin
      col_meta_q <= col_n;
      col_s_q    <= col_meta_q;
    end
  end

  // Scan FSM next-state: drive each row, sample it, then one debounce cycle.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    settle_d = settle_q;
    if (!scan_enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d  = StDrive;
          row_d    = '0;
          settle_d = SettleLoad;
        end
        StDrive: begin
          if (settle_q == '0) begin
            state_d = StSample;
          end else begin
            settle_d = settle_q - SettleW'(1);
          end
        end
        StSample: begin
          settle_d = SettleLoad;
          if (row_q == RowW'(ROWS - 1)) begin
            state_d = StUpdate;
          end else begin
            row_d   = row_q + RowW'(1);
            state_d = StDrive;
          end
        end
        StUpdate: begin
          row_d    = '0;
          settle_d = SettleLoad;
          state_d  = StDrive;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Row drive is registered from the next state so the pins never glitch.
  always_comb begin
    row_n_d = '1;
    if (state_d == StDrive || state_d == StSample) begin
      row_n_d = row_drive(row_d);
    end
  end

  // Capture the active row's columns into the raw frame image.
  always_comb begin
    raw_d = raw_q;
    if (state_q == StSample) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        raw_d[KEY_MAP[row_q][c]] = ~col_s_q[c];
      end
    end
  end

  // FSM, row, settle counter, row drive and raw frame registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      row_q    <= '0;
      settle_q <= '0;
      row_n_q  <= '1;
      raw_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      row_n_q  <= row_n_d;
      raw_q    <= raw_d;
    end
  end

  // A frame cut short by scan_enable dropping is never applied.
  assign update = (state_q == StUpdate) && scan_enable;

  for (genvar k = 0; k < KEYS; k++) begin : g_key
    vchip8_key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .update (update),
      .raw    (raw_q[k]),
      .state  (key_state[k]),
      .changed(changed[k])
    );
  end

  // One pulse per frame regardless of how many keys flipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_event_q <= 1'b0;
    end else begin
      key_event_q <= |changed;
    end
  end

  assign row_n     = row_n_q;
  assign key_event = key_event_q;

endmodule

// File: tb/tb_vchip8_keypad_scanner.sv
// Directed bench: SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, so a frame is 21 cycles.
// Cycle 1 is the first cycle after reset release; frame k starts at 1+21k,
// its UPDATE is at 21+21k and new key_state shows at 22+21k.
module tb_vchip8_keypad_scanner;

  localparam logic [3:0] KMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hC},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hA, 4'h0, 4'hB, 4'hF}
  };

  logic        clk = 1'b0;
  logic        reset_n;
  logic        scan_enable;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] key_state;
  logic        key_event;

  logic [15:0] keys;
  int          cyc;
  int          n_vec = 0;
  int          n_err = 0;
  int          ev_count = 0;

  vchip8_keypad_scanner #(
    .SETTLE_CYCLES (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scan_enable(scan_enable),
    .col_n      (col_n),
    .row_n      (row_n),
    .key_state  (key_state),
    .key_event  (key_event)
  );

  always #5 clk = ~clk;

  // Passive key matrix: a pressed key ties its column to its driven row.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && keys[KMAP[r][c]]) col_n[c] = 1'b0;
      end
    end
  end

  // Count key_event pulses.
  always @(negedge clk) begin
    if (!reset_n) ev_count <= 0;
    else if (key_event) ev_count <= ev_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_row;
    one         = 4'b0001;
    reset_n     = 1'b0;
    scan_enable = 1'b1;
    keys        = 16'h0000;
    cyc         = 0;

    // 1. Reset values and bare frame timing.
    repeat (3) @(negedge clk);
    check("rst_row_n", row_n, 4'hF);
    check("rst_key_state", key_state, 16'h0000);
    check("rst_key_event", key_event, 1'b0);
    reset_n = 1'b1;
    check("idle_row_n", row_n, 4'hF);
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c <= 20) exp_row = ~(one << ((c - 1) / 5));
      else if (c == 21) exp_row = 4'hF;
      else exp_row = 4'hE;
      check("frame_row_n", row_n, exp_row);
    end

    // 2. Key 5 held for frames 1..3.
    keys = 16'h0020;
    run_to(63);
    check("k5_before", key_state, 16'h0000);
    check("k5_no_event_yet", key_event, 1'b0);
    step();
    check("k5_pressed", key_state, 16'h0020);
    check("k5_event", key_event, 1'b1);
    step();
    check("k5_event_width", key_event, 1'b0);
    run_to(84);
    check("k5_hold", key_state, 16'h0020);
    check("k5_event_count", ev_count, 1);

    // 4. Release key 5 from frame 4.
    run_to(85);
    keys = 16'h0000;
    run_to(126);
    check("k5_rel_before", key_state, 16'h0020);
    step();
    check("k5_released", key_state, 16'h0000);
    check("k5_rel_event", key_event, 1'b1);
    step();
    check("k5_rel_count", ev_count, 2);

    // 3. Key A for frame 6 only.
    run_to(127);
    keys = 16'h0400;
    run_to(148);
    keys = 16'h0000;
    run_to(169);
    check("ka_bounce_f7", key_state, 16'h0000);
    run_to(190);
    check("ka_bounce_f8", key_state, 16'h0000);
    check("ka_no_event", ev_count, 2);

    // 5. Keys 1 and F together from frame 9.
    keys = 16'h8002;
    run_to(231);
    check("k1f_before", key_state, 16'h0000);
    step();
    check("k1f_pressed", key_state, 16'h8002);
    check("k1f_event", key_event, 1'b1);
    step();
    check("k1f_event_width", key_event, 1'b0);
    step();
    check("k1f_count", ev_count, 3);

    // 6. Drop scan_enable during row 2 DRIVE of frame 11 (cycles 242..245).
    run_to(243);
    check("pre_drop_row_n", row_n, 4'hB);
    scan_enable = 1'b0;
    step();
    check("drop_row_n", row_n, 4'hF);
    check("drop_key_state", key_state, 16'h8002);
    run_to(247);
    check("idle_row_n_hold", row_n, 4'hF);
    check("idle_key_state", key_state, 16'h8002);
    run_to(248);
    scan_enable = 1'b1;
    step();
    check("reenable_row_n", row_n, 4'hE);
    run_to(253);
    check("reenable_row0_len", row_n, 4'hE);
    step();
    check("reenable_row1", row_n, 4'hD);
    run_to(255);
    check("final_event_count", ev_count, 3);
    reset_n = 1'b0;
    #1;
    check("midrst_key_state", key_state, 16'h0000);
    check("midrst_row_n", row_n, 4'hF);
    check("midrst_key_event", key_event, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
